// File: rtl/bp_be_dcache_lce_cmd_decode.sv
// Dcache CCE-to-LCE command decoder. It writes the tag and data memories, returns
// sync/invalidate acks, and raises lce_ready_o once every CCE has synced.
module bp_be_dcache_lce_cmd_decode #(
    parameter int data_width_p  = 64,
    parameter int paddr_width_p = 22,
    parameter int ways_p        = 8,
    parameter int sets_p        = 64,
    parameter int num_cce_p     = 1,
    parameter int num_lce_p     = 2,
    localparam int bo_lp        = $clog2(data_width_p/8) + $clog2(ways_p),
    localparam int ix_lp        = $clog2(sets_p),
    localparam int tg_lp        = paddr_width_p - bo_lp - ix_lp,
    localparam int wy_lp        = $clog2(ways_p),
    localparam int block_lp     = data_width_p * ways_p,
    localparam int cce_id_w_lp  = (num_cce_p > 1) ? $clog2(num_cce_p) : 1
) (
    input  logic                     clk_i,
    input  logic                     reset_n_i,

    input  logic                     cmd_v_i,
    input  logic [2:0]               cmd_type_i,
    input  logic [paddr_width_p-1:0] cmd_addr_i,
    input  logic [wy_lp-1:0]         cmd_way_i,
    input  logic [1:0]               cmd_state_i,
    output logic                     cmd_yumi_o,

    input  logic                     data_cmd_v_i,
    input  logic [paddr_width_p-1:0] data_cmd_addr_i,
    input  logic [wy_lp-1:0]         data_cmd_way_i,
    input  logic [block_lp-1:0]      data_cmd_data_i,
    output logic                     data_cmd_yumi_o,

    output logic                     tag_mem_v_o,
    output logic [ix_lp-1:0]         tag_mem_index_o,
    output logic [wy_lp-1:0]         tag_mem_way_o,
    output logic [tg_lp-1:0]         tag_mem_tag_o,
    output logic [1:0]               tag_mem_state_o,
    input  logic                     tag_mem_ready_i,

    output logic                     data_mem_v_o,
    output logic [ix_lp-1:0]         data_mem_index_o,
    output logic [wy_lp-1:0]         data_mem_way_o,
    output logic [block_lp-1:0]      data_mem_data_o,
    input  logic                     data_mem_ready_i,

    output logic                     tag_set_o,
    output logic                     tag_set_wakeup_o,
    output logic                     cce_data_received_o,

    output logic                     lce_resp_v_o,
    output logic [1:0]               lce_resp_type_o,
    output logic [paddr_width_p-1:0] lce_resp_addr_o,
    output logic [cce_id_w_lp-1:0]   lce_resp_dst_o,
    input  logic                     lce_resp_yumi_i,

    output logic                     lce_ready_o
);

    localparam int cnt_w_lp = $clog2(num_cce_p + 1);

    localparam logic [1:0] st_ready    = 2'd0;
    localparam logic [1:0] st_sync_ack = 2'd1;
    localparam logic [1:0] st_inv_ack  = 2'd2;

    localparam logic [2:0] cmd_sync     = 3'd0;
    localparam logic [2:0] cmd_inv      = 3'd2;
    localparam logic [2:0] cmd_set      = 3'd3;
    localparam logic [2:0] cmd_set_wake = 3'd4;

    logic [1:0]               state_q, state_d;
    logic [paddr_width_p-1:0] resp_addr_q, resp_addr_d;
    logic [cnt_w_lp-1:0]      sync_cnt_q, sync_cnt_d;

    // Tag-write fields come straight from the command; only valid/yumi depend on state.
    assign tag_mem_index_o = cmd_addr_i[bo_lp +: ix_lp];
    assign tag_mem_tag_o   = cmd_addr_i[paddr_width_p-1 -: tg_lp];
    assign tag_mem_way_o   = cmd_way_i;
    assign tag_mem_state_o = (cmd_type_i == cmd_inv) ? 2'b00 : cmd_state_i;

    // NOTE: every output and next-state value gets a default first so no latch is inferred.
    always_comb begin
        state_d          = state_q;
        resp_addr_d      = resp_addr_q;
        sync_cnt_d       = sync_cnt_q;
        cmd_yumi_o       = 1'b0;
        tag_mem_v_o      = 1'b0;
        tag_set_o        = 1'b0;
        tag_set_wakeup_o = 1'b0;
        lce_resp_v_o     = 1'b0;
        lce_resp_type_o  = 2'd0;

        case (state_q)
            st_ready: begin
                if (cmd_v_i) begin
                    case (cmd_type_i)
                        cmd_sync: begin
                            cmd_yumi_o  = 1'b1;
                            resp_addr_d = cmd_addr_i;
                            state_d     = st_sync_ack;
                        end
                        cmd_inv: begin
                            tag_mem_v_o = 1'b1;
                            if (tag_mem_ready_i) begin
                                cmd_yumi_o  = 1'b1;
                                resp_addr_d = cmd_addr_i;
                                state_d     = st_inv_ack;
                            end
                        end
                        cmd_set: begin
                            tag_mem_v_o = 1'b1;
                            cmd_yumi_o  = tag_mem_ready_i;
                            tag_set_o   = tag_mem_ready_i;
                        end
                        cmd_set_wake: begin
                            tag_mem_v_o      = 1'b1;
                            cmd_yumi_o       = tag_mem_ready_i;
                            tag_set_wakeup_o = tag_mem_ready_i;
                        end
                        default: cmd_yumi_o = 1'b1;
                    endcase
                end
            end
            st_sync_ack: begin
                lce_resp_v_o    = 1'b1;
                lce_resp_type_o = 2'd0;
                if (lce_resp_yumi_i) begin
                    state_d = st_ready;
                    if (sync_cnt_q != cnt_w_lp'(num_cce_p))
                        sync_cnt_d = sync_cnt_q + 1'b1;
                end
            end
            st_inv_ack: begin
                lce_resp_v_o    = 1'b1;
                lce_resp_type_o = 2'd1;
                if (lce_resp_yumi_i)
                    state_d = st_ready;
            end
            default: state_d = st_ready;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_q     <= st_ready;
            resp_addr_q <= '0;
            sync_cnt_q  <= '0;
        end else begin
            state_q     <= state_d;
            resp_addr_q <= resp_addr_d;
            sync_cnt_q  <= sync_cnt_d;
        end
    end

    assign lce_resp_addr_o = resp_addr_q;
    assign lce_resp_dst_o  = (num_cce_p == 1) ? '0 : resp_addr_q[bo_lp +: cce_id_w_lp];
    assign lce_ready_o     = (sync_cnt_q == cnt_w_lp'(num_cce_p));

    // Fill path is independent of the command FSM.
    assign data_mem_v_o        = data_cmd_v_i;
    assign data_mem_index_o    = data_cmd_addr_i[bo_lp +: ix_lp];
    assign data_mem_way_o      = data_cmd_way_i;
    assign data_mem_data_o     = data_cmd_data_i;
    assign data_cmd_yumi_o     = data_cmd_v_i & data_mem_ready_i;
    assign cce_data_received_o = data_cmd_v_i & data_mem_ready_i;

    logic unused_bits;
    assign unused_bits = ^{data_cmd_addr_i[paddr_width_p-1:bo_lp+ix_lp],
                           data_cmd_addr_i[bo_lp-1:0], 1'(num_lce_p)};

endmodule
